// File: rtl/sky130_fd_io__xres_rst_seq_pkg.sv
// Shared types and constants for the XRES reset conditioner.
//   xres_seq_state_t : sequencer states
//   DEF_*            : default parameter values
//   cnt_width()      : bits needed to hold values 0..max_val
package sky130_fd_io__xres_rst_seq_pkg;

   typedef enum logic [1:0] {
      XS_ASSERT  = 2'd0,
      XS_RELEASE = 2'd1,
      XS_RUN     = 2'd2
   } xres_seq_state_t;

   localparam int unsigned DEF_SYNC_STAGES = 2;
   localparam int unsigned DEF_FILT_CYCLES = 16;
   localparam int unsigned DEF_N_DOMAINS   = 3;
   localparam int unsigned DEF_STEP_CYCLES = 4;

   // Width of a counter that must represent 0..max_val; never narrower than 1 bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      int unsigned w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sky130_fd_io__xres_rst_seq_if.sv
// Pad-side / reset-side signal bundle of the XRES reset conditioner.
//   XRES_H_N   : pad reset request, active low, asynchronous to the core clock
//   RST_N_OUT  : per-domain active-low resets, bit 0 released first
//   FILT_OUT   : debounced, synchronized XRES_H_N level
//   XRES_EVENT : one-cycle pulse when a filtered assertion is accepted
//   BUSY       : high while any domain is held or being released
// master = the pad/controller side, slave = the conditioner.
interface sky130_fd_io__xres_rst_seq_if
   import sky130_fd_io__xres_rst_seq_pkg::*;
#(
   parameter int unsigned N_DOMAINS = DEF_N_DOMAINS
);
   logic                 XRES_H_N;
   logic [N_DOMAINS-1:0] RST_N_OUT;
   logic                 FILT_OUT;
   logic                 XRES_EVENT;
   logic                 BUSY;

   modport master (
      output XRES_H_N,
      input  RST_N_OUT, FILT_OUT, XRES_EVENT, BUSY
   );

   modport slave (
      input  XRES_H_N,
      output RST_N_OUT, FILT_OUT, XRES_EVENT, BUSY
   );
endinterface

// File: rtl/sky130_fd_io__xres_sync.sv
// Multi-flop synchronizer for pad-facing asynchronous inputs.
//   clk     : destination clock
//   rst     : asynchronous active-high reset, chain clears to 0
//   async_i : asynchronous input; anything but a clean 1 is taken as 0
//   sync_o  : synchronized level, SYNC_STAGES-1 edges after first capture
module sky130_fd_io__xres_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic sync_o
);

   logic [SYNC_STAGES-1:0] chain_q;
   logic [SYNC_STAGES-1:0] chain_d;

   // An unpowered or floating pad (X/Z) must read as a reset request.
   always_comb begin
      chain_d = {chain_q[SYNC_STAGES-2:0], (async_i === 1'b1)};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) chain_q <= '0;
      else     chain_q <= chain_d;
   end

   assign sync_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/sky130_fd_io__xres_rst_seq.sv
// XRES reset conditioner: synchronizes and debounces the pad reset, then
// releases N_DOMAINS active-low core resets one at a time.
//   CLK     : sole clock
//   RESET   : asynchronous active-high power-on reset
//   xres_if : slave side of the pad/reset bundle (XRES_H_N in;
//             RST_N_OUT, FILT_OUT, XRES_EVENT, BUSY out, all registered)
module sky130_fd_io__xres_rst_seq
   import sky130_fd_io__xres_rst_seq_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int unsigned FILT_CYCLES = DEF_FILT_CYCLES,
   parameter int unsigned N_DOMAINS   = DEF_N_DOMAINS,
   parameter int unsigned STEP_CYCLES = DEF_STEP_CYCLES
) (
   input logic                          CLK,
   input logic                          RESET,
   sky130_fd_io__xres_rst_seq_if.slave  xres_if
);

   localparam int unsigned CNT_W  = cnt_width(FILT_CYCLES);
   localparam int unsigned STEP_W = cnt_width(STEP_CYCLES);
   localparam int unsigned IDX_W  = cnt_width(N_DOMAINS);

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(FILT_CYCLES - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DOMAINS - 1);

   logic                 sync_out;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 filt_q, filt_d;
   xres_seq_state_t      state_q, state_d;
   logic [STEP_W-1:0]    step_q, step_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [N_DOMAINS-1:0] rst_n_q, rst_n_d;
   logic                 evt_q, evt_d;
   logic                 busy_q, busy_d;

   sky130_fd_io__xres_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (CLK),
      .rst     (RESET),
      .async_i (xres_if.XRES_H_N),
      .sync_o  (sync_out)
   );

   // Debounce: the filtered level flips only after FILT_CYCLES consecutive mismatches.
   always_comb begin
      cnt_d  = '0;
      filt_d = filt_q;
      if (sync_out != filt_q) begin
         if (cnt_q == CNT_LAST) filt_d = ~filt_q;
         else                   cnt_d  = cnt_q + CNT_W'(1);
      end
   end

   // Sequencer. Release starts on the same edge FILT_OUT rises (filt_d) so that
   // domain i comes out STEP_CYCLES*(i+1) edges later; assertion reacts to the
   // registered level, one edge after FILT_OUT falls.
   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      idx_d   = idx_q;
      rst_n_d = rst_n_q;
      evt_d   = 1'b0;
      unique case (state_q)
         XS_ASSERT: begin
            rst_n_d = '0;
            step_d  = '0;
            idx_d   = '0;
            if (filt_d) state_d = XS_RELEASE;
         end
         XS_RELEASE: begin
            if (!filt_q) begin
               state_d = XS_ASSERT;
               rst_n_d = '0;
               step_d  = '0;
               idx_d   = '0;
               evt_d   = 1'b1;
            end else if (step_q == STEP_LAST) begin
               step_d  = '0;
               rst_n_d = rst_n_q | (N_DOMAINS'(1) << idx_q);
               idx_d   = idx_q + IDX_W'(1);
               if (idx_q == IDX_LAST) state_d = XS_RUN;
            end else begin
               step_d = step_q + STEP_W'(1);
            end
         end
         XS_RUN: begin
            rst_n_d = '1;
            if (!filt_q) begin
               state_d = XS_ASSERT;
               rst_n_d = '0;
               step_d  = '0;
               idx_d   = '0;
               evt_d   = 1'b1;
            end
         end
         default: begin
            state_d = XS_ASSERT;
            rst_n_d = '0;
         end
      endcase
      busy_d = (state_d != XS_RUN);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         cnt_q   <= '0;
         filt_q  <= 1'b0;
         state_q <= XS_ASSERT;
         step_q  <= '0;
         idx_q   <= '0;
         rst_n_q <= '0;
         evt_q   <= 1'b0;
         busy_q  <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         filt_q  <= filt_d;
         state_q <= state_d;
         step_q  <= step_d;
         idx_q   <= idx_d;
         rst_n_q <= rst_n_d;
         evt_q   <= evt_d;
         busy_q  <= busy_d;
      end
   end

   assign xres_if.RST_N_OUT  = rst_n_q;
   assign xres_if.FILT_OUT   = filt_q;
   assign xres_if.XRES_EVENT = evt_q;
   assign xres_if.BUSY       = busy_q;

endmodule

// File: tb/tb_sky130_fd_io__xres_rst_seq.sv
// Bench for the XRES reset conditioner. Three instances share clock, reset and
// pad input: defaults, the 1/1/1 corner, and a slow-step/short-filter variant
// that lets a reassertion land mid-release. A timestamp-based model predicts
// every output each cycle; literal checks pin the model at known edges.
module tb_sky130_fd_io__xres_rst_seq;

   logic clk;
   logic rst;
   logic xres;

   int n_checks = 0;
   int n_errors = 0;

   sky130_fd_io__xres_rst_seq_if #(.N_DOMAINS(3)) if0 ();
   sky130_fd_io__xres_rst_seq_if #(.N_DOMAINS(1)) if1 ();
   sky130_fd_io__xres_rst_seq_if #(.N_DOMAINS(3)) if2 ();

   assign if0.XRES_H_N = xres;
   assign if1.XRES_H_N = xres;
   assign if2.XRES_H_N = xres;

   sky130_fd_io__xres_rst_seq #(
      .SYNC_STAGES(2), .FILT_CYCLES(16), .N_DOMAINS(3), .STEP_CYCLES(4)
   ) dut0 (.CLK(clk), .RESET(rst), .xres_if(if0));

   sky130_fd_io__xres_rst_seq #(
      .SYNC_STAGES(2), .FILT_CYCLES(1), .N_DOMAINS(1), .STEP_CYCLES(1)
   ) dut1 (.CLK(clk), .RESET(rst), .xres_if(if1));

   sky130_fd_io__xres_rst_seq #(
      .SYNC_STAGES(3), .FILT_CYCLES(4), .N_DOMAINS(3), .STEP_CYCLES(8)
   ) dut2 (.CLK(clk), .RESET(rst), .xres_if(if2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int p_sync(input int m);
      return (m == 2) ? 3 : 2;
   endfunction
   function automatic int p_filt(input int m);
      case (m)
         0: return 16;
         1: return 1;
         default: return 4;
      endcase
   endfunction
   function automatic int p_ndom(input int m);
      return (m == 1) ? 1 : 3;
   endfunction
   function automatic int p_step(input int m);
      case (m)
         0: return 4;
         1: return 1;
         default: return 8;
      endcase
   endfunction

   // Model state: recent pad samples, recent synchronized values, filtered
   // level, whether the reset sequence is running and the edge it started on.
   bit [31:0] m_smp    [3];
   bit [31:0] m_sh     [3];
   bit        m_filt   [3];
   bit        m_active [3];
   bit        m_evt    [3];
   int        m_edge   [3];
   int        m_t0     [3];

   task automatic model_reset(input int m);
      m_smp[m] = '0; m_sh[m] = '0; m_filt[m] = 1'b0; m_active[m] = 1'b0;
      m_evt[m] = 1'b0; m_edge[m] = 0; m_t0[m] = 0;
   endtask

   task automatic model_step(input int m, input bit v);
      bit        old;
      bit        s;
      bit [31:0] mask;
      old      = m_filt[m];
      m_smp[m] = {m_smp[m][30:0], v};
      s        = m_smp[m][p_sync(m)];
      m_sh[m]  = {m_sh[m][30:0], s};
      mask     = (32'd1 << p_filt(m)) - 32'd1;
      // Flip when the last FILT_CYCLES synchronized values all disagree.
      if (((m_sh[m] ^ {32{old}}) & mask) == mask) m_filt[m] = ~old;
      m_edge[m]++;
      m_evt[m] = 1'b0;
      if (m_active[m] && !old) begin
         m_active[m] = 1'b0;
         m_evt[m]    = 1'b1;
      end else if (!m_active[m] && m_filt[m]) begin
         m_active[m] = 1'b1;
         m_t0[m]     = m_edge[m];
      end
   endtask

   task automatic model_out(input int m, output int rst_exp, output int busy_exp);
      int n;
      if (!m_active[m]) begin
         rst_exp  = 0;
         busy_exp = 1;
      end else begin
         n = (m_edge[m] - m_t0[m]) / p_step(m);
         if (n > p_ndom(m)) n = p_ndom(m);
         rst_exp  = (1 << n) - 1;
         busy_exp = (n < p_ndom(m)) ? 1 : 0;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic dut_out(input int m, output int r, output int f, output int e, output int b);
      case (m)
         0: begin r = 32'(if0.RST_N_OUT); f = 32'(if0.FILT_OUT); e = 32'(if0.XRES_EVENT); b = 32'(if0.BUSY); end
         1: begin r = 32'(if1.RST_N_OUT); f = 32'(if1.FILT_OUT); e = 32'(if1.XRES_EVENT); b = 32'(if1.BUSY); end
         default: begin r = 32'(if2.RST_N_OUT); f = 32'(if2.FILT_OUT); e = 32'(if2.XRES_EVENT); b = 32'(if2.BUSY); end
      endcase
   endtask

   // Compare every instance against the model on every falling edge.
   always @(negedge clk) begin
      for (int m = 0; m < 3; m++) begin
         int r, f, e, b, re, be;
         dut_out(m, r, f, e, b);
         model_out(m, re, be);
         chk($sformatf("i%0d rst_n_out", m), r, re);
         chk($sformatf("i%0d filt_out", m), f, 32'(m_filt[m]));
         chk($sformatf("i%0d xres_event", m), e, 32'(m_evt[m]));
         chk($sformatf("i%0d busy", m), b, be);
      end
   end

   // One clock: present v, wait for the edge, advance the model.
   task automatic cycle(input logic v);
      xres = v;
      @(posedge clk);
      #1;
      for (int m = 0; m < 3; m++) begin
         if (rst) model_reset(m);
         else     model_step(m, xres === 1'b1);
      end
   endtask

   // Raise RESET between edges; outputs must clear with no clock.
   task automatic async_reset();
      #2;
      rst = 1'b1;
      #1;
      for (int m = 0; m < 3; m++) begin
         int r, f, e, b;
         dut_out(m, r, f, e, b);
         chk($sformatf("i%0d async rst_n_out", m), r, 0);
         chk($sformatf("i%0d async filt_out", m), f, 0);
         chk($sformatf("i%0d async xres_event", m), e, 0);
         chk($sformatf("i%0d async busy", m), b, 1);
         model_reset(m);
      end
      cycle(xres);
      cycle(xres);
      rst = 1'b0;
   endtask

   initial begin
      int   r, f, e, b;
      int   remaining;
      logic v;
      int   sel;

      rst  = 1'b1;
      xres = 1'b1;
      for (int m = 0; m < 3; m++) model_reset(m);
      repeat (3) cycle(1'b1);
      dut_out(0, r, f, e, b);
      chk("por rst_n_out", r, 0);
      chk("por filt_out", f, 0);
      chk("por xres_event", e, 0);
      chk("por busy", b, 1);
      rst = 1'b0;

      // Power-on release with the pad already high.
      for (int k = 0; k <= 31; k++) begin
         cycle(1'b1);
         dut_out(0, r, f, e, b);
         if (k == 16) chk("rel filt before 17", f, 0);
         if (k == 17) chk("rel filt at 17", f, 1);
         if (k == 20) chk("rel rst at 20", r, 0);
         if (k == 21) chk("rel rst at 21", r, 1);
         if (k == 25) chk("rel rst at 25", r, 3);
         if (k == 28) chk("rel busy at 28", b, 1);
         if (k == 29) begin
            chk("rel rst at 29", r, 7);
            chk("rel busy at 29", b, 0);
         end
         dut_out(1, r, f, e, b);
         if (k == 1) chk("corner filt at 1", f, 0);
         if (k == 2) begin
            chk("corner filt at 2", f, 1);
            chk("corner rst at 2", r, 0);
         end
         if (k == 3) begin
            chk("corner rst at 3", r, 1);
            chk("corner busy at 3", b, 0);
         end
      end

      // Fifteen-cycle low in RUN is swallowed.
      repeat (15) cycle(1'b0);
      repeat (20) cycle(1'b1);
      dut_out(0, r, f, e, b);
      chk("glitch15 filt", f, 1);
      chk("glitch15 rst", r, 7);

      // Sixteen-cycle low is accepted.
      for (int k = 0; k <= 19; k++) begin
         cycle((k < 16) ? 1'b0 : 1'b1);
         dut_out(0, r, f, e, b);
         if (k == 16) chk("assert16 filt at 16", f, 1);
         if (k == 17) begin
            chk("assert16 filt at 17", f, 0);
            chk("assert16 rst at 17", r, 7);
         end
         if (k == 18) begin
            chk("assert16 rst at 18", r, 0);
            chk("assert16 event at 18", e, 1);
         end
         if (k == 19) chk("assert16 event at 19", e, 0);
      end
      repeat (50) cycle(1'b1);

      // Chatter with 8-cycle runs never reaches the default filter length.
      for (int i = 0; i < 200; i++) cycle(((i / 8) % 2 == 0) ? 1'b0 : 1'b1);
      dut_out(0, r, f, e, b);
      chk("chatter filt", f, 1);
      repeat (40) cycle(1'b1);

      // Undriven pad for 20 cycles, then recover.
      repeat (20) cycle(1'bx);
      repeat (50) cycle(1'b1);

      // Asynchronous reset in RUN, then full re-release.
      async_reset();
      repeat (40) cycle(1'b1);

      // Random runs of high/low/X with occasional asynchronous resets.
      remaining = 0;
      v = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (remaining == 0) begin
            remaining = $urandom_range(1, 40);
            sel = $urandom_range(0, 15);
            v = (sel == 0) ? 1'bx : ((sel < 7) ? 1'b0 : 1'b1);
         end
         remaining--;
         if ($urandom_range(0, 299) == 0) async_reset();
         else                             cycle(v);
      end
      repeat (60) cycle(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
